// File: rtl/kb_ctrl.sv
// PS/2 keyboard controller: turns receiver scan-code events into ASCII characters,
// tracks Shift/Ctrl/CapsLock, queues them in a FIFO and serves CPU data/status reads.
module kb_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kb_ready,
  input  logic [7:0]  kb_code,
  input  logic        kb_e0,
  input  logic        kb_break,
  input  logic        rd_data,
  input  logic        rd_stat,
  output logic [15:0] cpu_dout,
  output logic        data_avail,
  output logic        overflow
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StPush   = 2'd2;

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic          kb_ready_q;
  logic [1:0]    state_q, state_d;
  logic [7:0]    code_q;
  logic          e0_q, brk_q;
  logic          shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d;
  logic [7:0]    char_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   cpu_dout_q, cpu_dout_d;

  logic       kb_event;
  logic       char_vld;
  logic [7:0] char_val;
  logic [4:0] letter;
  logic       empty, full, push, pop, wr_en, ovf_set;

  // Set-2 US-layout letter codes mapped to alphabet index 1..26; 0 means not a letter.
  function automatic logic [4:0] letter_idx(input logic [7:0] c);
    case (c)
      8'h1C: return 5'd1;   8'h32: return 5'd2;   8'h21: return 5'd3;   8'h23: return 5'd4;
      8'h24: return 5'd5;   8'h2B: return 5'd6;   8'h34: return 5'd7;   8'h33: return 5'd8;
      8'h43: return 5'd9;   8'h3B: return 5'd10;  8'h42: return 5'd11;  8'h4B: return 5'd12;
      8'h3A: return 5'd13;  8'h31: return 5'd14;  8'h44: return 5'd15;  8'h4D: return 5'd16;
      8'h15: return 5'd17;  8'h2D: return 5'd18;  8'h1B: return 5'd19;  8'h2C: return 5'd20;
      8'h3C: return 5'd21;  8'h2A: return 5'd22;  8'h1D: return 5'd23;  8'h22: return 5'd24;
      8'h35: return 5'd25;  8'h1A: return 5'd26;
      default: return 5'd0;
    endcase
  endfunction

  assign kb_event = kb_ready & ~kb_ready_q;

  // Modifiers follow the raw receiver inputs on the event edge, before translation runs.
  always_comb begin
    shift_d = shift_q;
    ctrl_d  = ctrl_q;
    caps_d  = caps_q;
    if (state_q == StIdle && kb_event) begin
      case (kb_code)
        8'h12, 8'h59: shift_d = ~kb_break;
        8'h14:        ctrl_d  = ~kb_break;
        8'h58:        caps_d  = kb_break ? caps_q : ~caps_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    char_vld = 1'b0;
    char_val = 8'h00;
    letter   = letter_idx(code_q);
    if (!brk_q) begin
      if (e0_q) begin
        if (code_q == 8'h5A) begin
          char_vld = 1'b1;
          char_val = 8'h0D;
        end
      end else if (letter != 5'd0) begin
        char_vld = 1'b1;
        if (ctrl_q)                char_val = {3'b000, letter};
        else if (shift_q ^ caps_q) char_val = 8'h40 + {3'b000, letter};
        else                       char_val = 8'h60 + {3'b000, letter};
      end else begin
        char_vld = 1'b1;
        case (code_q)
          8'h45: char_val = 8'h30;
          8'h16: char_val = 8'h31;
          8'h1E: char_val = 8'h32;
          8'h26: char_val = 8'h33;
          8'h25: char_val = 8'h34;
          8'h2E: char_val = 8'h35;
          8'h36: char_val = 8'h36;
          8'h3D: char_val = 8'h37;
          8'h3E: char_val = 8'h38;
          8'h46: char_val = 8'h39;
          8'h29: char_val = 8'h20;
          8'h5A: char_val = 8'h0D;
          8'h66: char_val = 8'h08;
          8'h76: char_val = 8'h1B;
          8'h0D: char_val = 8'h09;
          default: char_vld = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (kb_event) state_d = StDecode;
      StDecode: state_d = char_vld ? StPush : StIdle;
      StPush:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign push    = (state_q == StPush);
  assign pop     = rd_data & ~empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr_en) count_d = count_q - 1'b1;
  end

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set)                overflow_d = 1'b1;
    else if (rd_stat && !rd_data) overflow_d = 1'b0;
  end

  always_comb begin
    cpu_dout_d = cpu_dout_q;
    if (rd_data)      cpu_dout_d = empty ? 16'h0000 : {8'h00, mem[rd_ptr_q]};
    else if (rd_stat) cpu_dout_d = {13'b0, overflow_q, full, ~empty};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      kb_ready_q <= 1'b0;
      state_q    <= StIdle;
      code_q     <= 8'h00;
      e0_q       <= 1'b0;
      brk_q      <= 1'b0;
      shift_q    <= 1'b0;
      ctrl_q     <= 1'b0;
      caps_q     <= 1'b0;
      char_q     <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cpu_dout_q <= 16'h0000;
    end else begin
      kb_ready_q <= kb_ready;
      state_q    <= state_d;
      shift_q    <= shift_d;
      ctrl_q     <= ctrl_d;
      caps_q     <= caps_d;
      if (state_q == StIdle && kb_event) begin
        code_q <= kb_code;
        e0_q   <= kb_e0;
        brk_q  <= kb_break;
      end
      if (state_q == StDecode) char_q <= char_val;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= char_q;
  end

  assign cpu_dout   = cpu_dout_q;
  assign data_avail = ~empty;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_kb_ctrl.sv
// Directed self-checking bench for kb_ctrl: translation, modifiers, FIFO boundaries,
// status reads and mid-operation reset.
module tb_kb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        kb_ready;
  logic [7:0]  kb_code;
  logic        kb_e0;
  logic        kb_break;
  logic        rd_data;
  logic        rd_stat;
  logic [15:0] cpu_dout;
  logic        data_avail;
  logic        overflow;

  int n_assert = 0;
  int n_fail   = 0;

  kb_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .kb_ready   (kb_ready),
    .kb_code    (kb_code),
    .kb_e0      (kb_e0),
    .kb_break   (kb_break),
    .rd_data    (rd_data),
    .rd_stat    (rd_stat),
    .cpu_dout   (cpu_dout),
    .data_avail (data_avail),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] code, input logic e0, input logic brk);
    @(negedge clk);
    kb_code  = code;
    kb_e0    = e0;
    kb_break = brk;
    kb_ready = 1'b1;
    repeat (3) @(negedge clk);
    kb_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_data(output logic [15:0] v);
    @(negedge clk);
    rd_data = 1'b1;
    @(negedge clk);
    rd_data = 1'b0;
    v = cpu_dout;
  endtask

  task automatic read_stat(output logic [15:0] v);
    @(negedge clk);
    rd_stat = 1'b1;
    @(negedge clk);
    rd_stat = 1'b0;
    v = cpu_dout;
  endtask

  // Codes for a..q in alphabet order.
  logic [7:0] letters [17] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};

  initial begin
    logic [15:0] v;
    rst = 1'b0; kb_ready = 1'b0; kb_code = 8'h00; kb_e0 = 1'b0; kb_break = 1'b0;
    rd_data = 1'b0; rd_stat = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset cpu_dout", cpu_dout, 16'h0000);
    chk("reset data_avail", {15'b0, data_avail}, 16'h0000);
    chk("reset overflow", {15'b0, overflow}, 16'h0000);
    rst = 1'b1;

    // 1) long level yields one event; data_avail two edges after the sampling edge
    @(negedge clk);
    kb_code = 8'h1C; kb_ready = 1'b1;
    @(negedge clk);
    chk("t1 avail edge+0", {15'b0, data_avail}, 16'h0000);
    @(negedge clk);
    chk("t1 avail edge+1", {15'b0, data_avail}, 16'h0000);
    @(negedge clk);
    chk("t1 avail edge+2", {15'b0, data_avail}, 16'h0001);
    repeat (47) @(negedge clk);
    kb_ready = 1'b0;
    repeat (3) @(negedge clk);
    read_data(v); chk("t1 read a", v, 16'h0061);
    read_data(v); chk("t1 single entry", v, 16'h0000);

    // 2) shift and caps
    send(8'h12, 0, 0); send(8'h1C, 0, 0); send(8'h12, 0, 1); send(8'h1C, 0, 0);
    read_data(v); chk("t2 shift A", v, 16'h0041);
    read_data(v); chk("t2 unshift a", v, 16'h0061);
    send(8'h58, 0, 0); send(8'h32, 0, 0);
    read_data(v); chk("t2 caps B", v, 16'h0042);
    send(8'h58, 0, 1); send(8'h32, 0, 0);
    read_data(v); chk("t2 caps break ignored", v, 16'h0042);
    send(8'h59, 0, 0); send(8'h32, 0, 0);
    read_data(v); chk("t2 shift^caps b", v, 16'h0062);
    send(8'h59, 0, 1); send(8'h58, 0, 0);

    // 3) ctrl, breaks, E0 handling, misc codes
    send(8'h14, 0, 0); send(8'h21, 0, 0);
    read_data(v); chk("t3 ctrl C", v, 16'h0003);
    send(8'h14, 1, 1);
    send(8'h21, 0, 1); send(8'h1C, 0, 1); send(8'h75, 1, 0); send(8'h12, 0, 0);
    chk("t3 nothing queued", {15'b0, data_avail}, 16'h0000);
    send(8'h12, 0, 1);
    send(8'h5A, 1, 0); send(8'h45, 0, 0); send(8'h29, 0, 0); send(8'h0D, 0, 0);
    send(8'h1A, 0, 0);
    read_data(v); chk("t3 E0 enter", v, 16'h000D);
    read_data(v); chk("t3 digit 0", v, 16'h0030);
    read_data(v); chk("t3 space", v, 16'h0020);
    read_data(v); chk("t3 tab", v, 16'h0009);
    read_data(v); chk("t3 z", v, 16'h007A);

    // 4) overflow on DEPTH+1 pushes
    for (int i = 0; i < 17; i++) send(letters[i], 0, 0);
    chk("t4 overflow pin", {15'b0, overflow}, 16'h0001);
    read_stat(v); chk("t4 stat ovf", v, 16'h0007);
    read_stat(v); chk("t4 stat cleared", v, 16'h0003);
    for (int i = 0; i < 16; i++) begin
      read_data(v); chk($sformatf("t4 drain %0d", i), v, 16'h0061 + 16'(i));
    end
    read_data(v); chk("t4 empty read", v, 16'h0000);
    read_stat(v); chk("t4 stat empty", v, 16'h0000);

    // 5) full FIFO, pop coincident with PUSH
    for (int i = 0; i < 16; i++) send(letters[i], 0, 0);
    @(negedge clk);
    kb_code = 8'h15; kb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_data = 1'b1;
    @(negedge clk);
    rd_data = 1'b0; kb_ready = 1'b0;
    chk("t5 pop head", cpu_dout, 16'h0061);
    repeat (3) @(negedge clk);
    read_stat(v); chk("t5 stat full no ovf", v, 16'h0003);
    for (int i = 0; i < 16; i++) begin
      read_data(v); chk($sformatf("t5 drain %0d", i), v, 16'h0062 + 16'(i));
    end
    chk("t5 drained", {15'b0, data_avail}, 16'h0000);

    // 6) reset while DECODE with entries queued and shift held
    send(8'h12, 0, 0);
    send(8'h1C, 0, 0); send(8'h32, 0, 0); send(8'h21, 0, 0);
    chk("t6 queued", {15'b0, data_avail}, 16'h0001);
    @(negedge clk);
    kb_code = 8'h1C; kb_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; kb_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t6 avail", {15'b0, data_avail}, 16'h0000);
    chk("t6 cpu_dout", cpu_dout, 16'h0000);
    repeat (3) @(negedge clk);
    chk("t6 no in-flight push", {15'b0, data_avail}, 16'h0000);
    read_stat(v); chk("t6 stat", v, 16'h0000);
    send(8'h1C, 0, 0);
    read_data(v); chk("t6 after reset a", v, 16'h0061);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
